regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Multi-cycle control block that drives the CPU's 8 x 4-bit register file from the access side.
- Accepts one instruction through a valid/ready handshake and issues the two register read addresses.
- Consumes the register file's one-cycle registered read data, computes a 4-bit ALU result and flags, then performs a single-cycle writeback.
- Sits between the instruction source and the register file, and is the sole driver of its read/write ports.

Parameters:
DATA_WIDTH, 4, register/operand width
ADDR_WIDTH, 3, register address width (2**ADDR_WIDTH registers)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
instr  input  16  instruction: [15:13] op, [12:10] dest, [9:7] src1, [6:4] src2, [3:0] imm
instr_valid  input  1  instruction present
instr_ready  output  1  sequencer can accept (high only in IDLE)
read_address1  output  ADDR_WIDTH  to regfile, src1
read_address2  output  ADDR_WIDTH  to regfile, src2
read_data1  input  DATA_WIDTH  from regfile, valid one cycle after address presented
read_data2  input  DATA_WIDTH  from regfile, valid one cycle after address presented
write_address  output  ADDR_WIDTH  to regfile, dest
write_data  output  DATA_WIDTH  to regfile, result
write_enable  output  1  to regfile, one-cycle write strobe
carry  output  1  carry/borrow flag
zero  output  1  zero flag
done  output  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset: one clock domain; reset_n is asynchronous and active-low. While reset_n=0:
  - state=IDLE;
  - all address/data outputs are 0;
  - write_enable=0, carry=0, zero=0, done=0;
  - captured instruction register is 0.
  - Effect is immediate, not clock-dependent.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - instr_ready=1, decoded from state.
  - On a clk edge with instr_valid=1, capture instr and go to READ.
  - instr_valid=0 stays IDLE.
- READ (1 cycle):
  - read_address1=src1 and read_address2=src2, registered from the captured instr.
  - Addresses are held stable through EXEC.
  - Go to EXEC.
- EXEC (1 cycle): read_data1/2 are valid now. Compute result; register write_data, carry and zero at the end of the cycle; go to WRITE.
  - 000 ADD: 5-bit sum; result=sum[3:0], carry=sum[4].
  - 001 SUB: result=(src1-src2) mod 16; carry=1 iff src1<src2 (borrow).
  - 010 AND, 011 OR, 100 XOR: bitwise; carry=0.
  - 101 LOADI: result=imm; carry=0; read data ignored.
  - 110 MOV: result=read_data1; carry=0.
  - 111 NOP: result not written; carry and zero unchanged.
  - zero=(result==0) for every op except NOP.
- WRITE (1 cycle):
  - write_address=dest and write_enable=1 (0 for NOP), for exactly this cycle.
  - Regfile commits at the closing edge.
  - Go to IDLE with done registered high for one cycle.
- Latency: acceptance edge E0; READ cycle 1, EXEC cycle 2, WRITE cycle 3; done and instr_ready high in cycle 4. Fixed for all ops.
- Throughput: one instruction per 4 cycles. A new instruction may be accepted in the same cycle done is high.
- No read-after-write hazard: a write commits at the end of WRITE, and the next READ is at least 2 edges later.
- instr_valid during READ/EXEC/WRITE is ignored (instr_ready=0). The source holds instr until accepted.
- dest == src1/src2: reads use pre-write values. The write lands after EXEC and is visible to the next instruction.
- Reset asserted mid-instruction:
  - the instruction is abandoned;
  - write_enable drops immediately;
  - no partial writeback;
  - flags cleared.
- After reset_n rises, the first acceptance is possible on the first clk edge.

Test Plan:
1. After reset, LOADI r1=9 then LOADI r2=7 -> each write: write_enable high exactly 3 cycles after acceptance; write_address=1/2; write_data=9/7; zero=0, carry=0; done 1 cycle later.
2. Following ADD r3=r1+r2 -> read_address1=1, read_address2=2 in READ; write_data=0 to address 3; carry=1, zero=1.
3. SUB r4=r2-r1 -> write_data=14 to address 4, carry=1, zero=0. Then SUB r5=r1-r2 -> write_data=2, carry=0.
4. NOP after case 3 -> write_enable never asserted; carry=0, zero=0 retained; done still pulses in cycle 4.
5. instr_valid held high with back-to-back MOV r6=r4 and XOR r7=r6^r6 -> second accepted only in the done cycle; r6=14; r7 write_data=0, zero=1.
6. Assert reset_n=0 during EXEC of ADD r1=r1+r1 -> write_enable 0, flags 0, instr_ready 1 asynchronously; no write to r1 occurs.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Four-phase sequencer driving an 8 x 4-bit register file: accept, read, execute, write back.
// Holds one instruction at a time and pulses done when it retires.
module regfile_sequencer #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] read_address1,
  output logic [ADDR_WIDTH-1:0] read_address2,
  input  logic [DATA_WIDTH-1:0] read_data1,
  input  logic [DATA_WIDTH-1:0] read_data2,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_enable,
  output logic                  carry,
  output logic                  zero,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

  localparam logic [2:0] OpAdd   = 3'd0;
  localparam logic [2:0] OpSub   = 3'd1;
  localparam logic [2:0] OpAnd   = 3'd2;
  localparam logic [2:0] OpOr    = 3'd3;
  localparam logic [2:0] OpXor   = 3'd4;
  localparam logic [2:0] OpLoadi = 3'd5;
  localparam logic [2:0] OpMov   = 3'd6;
  localparam logic [2:0] OpNop   = 3'd7;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [ADDR_WIDTH-1:0] ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  we_q, we_d, carry_q, carry_d, zero_q, zero_d, done_q, done_d;

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;

  // SUB uses the extra bit as the borrow out: it is set exactly when src1 < src2.
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (op_q)
      OpAdd: begin
        sum       = {1'b0, read_data1} + {1'b0, read_data2};
        alu_res   = sum[DATA_WIDTH-1:0];
        alu_carry = sum[DATA_WIDTH];
      end
      OpSub: begin
        sum       = {1'b0, read_data1} - {1'b0, read_data2};
        alu_res   = sum[DATA_WIDTH-1:0];
        alu_carry = sum[DATA_WIDTH];
      end
      OpAnd:   alu_res = read_data1 & read_data2;
      OpOr:    alu_res = read_data1 | read_data2;
      OpXor:   alu_res = read_data1 ^ read_data2;
      OpLoadi: alu_res = imm_q;
      OpMov:   alu_res = read_data1;
      OpNop:   alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dest_d  = dest_q;
    imm_d   = imm_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          op_d    = instr[15:13];
          dest_d  = instr[12:10];
          ra1_d   = instr[9:7];
          ra2_d   = instr[6:4];
          imm_d   = instr[3:0];
          state_d = StRead;
        end
      end
      StRead: state_d = StExec;
      StExec: begin
        wa_d = dest_q;
        if (op_q != OpNop) begin
          wd_d    = alu_res;
          carry_d = alu_carry;
          zero_d  = (alu_res == '0);
          we_d    = 1'b1;
        end
        state_d = StWrite;
      end
      StWrite: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      dest_q  <= '0;
      imm_q   <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      imm_q   <= imm_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign instr_ready   = (state_q == StIdle);
  assign read_address1 = ra1_q;
  assign read_address2 = ra2_q;
  assign write_address = wa_q;
  assign write_data    = wd_q;
  assign write_enable  = we_q;
  assign carry         = carry_q;
  assign zero          = zero_q;
  assign done          = done_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: acts as the register file, keeps an instruction-level model,
// and applies directed instructions with hand-computed results.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  read_address1, read_address2, write_address;
  logic [3:0]  read_data1 = '0, read_data2 = '0;
  logic [3:0]  write_data;
  logic        write_enable, carry, zero, done;

  regfile_sequencer #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .read_address1 (read_address1),
    .read_address2 (read_address2),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .write_address (write_address),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .carry         (carry),
    .zero          (zero),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file seen by the DUT: registered reads, write on strobe.
  logic [3:0] rf [8];
  always @(posedge clk) begin
    if (write_enable === 1'b1) rf[write_address] <= write_data;
    read_data1 <= rf[read_address1];
    read_data2 <= rf[read_address2];
  end

  // Instruction-level model: architectural registers updated at retirement,
  // outputs predicted by the cycle offset since acceptance.
  logic [3:0] mrf [8];
  int         m_phase = 0;
  bit         m_done = 0, m_we = 0, m_c = 0, m_z = 0;
  logic [2:0] m_op = '0, m_dest = '0, m_s1 = '0, m_s2 = '0;
  logic [3:0] m_imm = '0, m_wd = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_done = 0; m_we = 0; m_c = 0; m_z = 0;
    end else begin
      case (m_phase)
        0: begin
          m_done = 0;
          if (instr_valid) begin
            {m_op, m_dest, m_s1, m_s2, m_imm} = instr;
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        2: begin
          int a, b, r;
          a = int'(mrf[m_s1]);
          b = int'(mrf[m_s2]);
          r = 0;
          case (m_op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = int'(m_imm);
            3'd6: r = a;
            default: r = 0;
          endcase
          if (m_op != 3'd7) begin
            m_c  = (m_op == 3'd0) ? (r > 15) : (m_op == 3'd1) ? (a < b) : 1'b0;
            m_wd = 4'(r & 15);
            m_z  = ((r & 15) == 0);
            m_we = 1;
          end else begin
            m_we = 0;
          end
          m_phase = 3;
        end
        default: begin
          if (m_we) mrf[m_dest] = m_wd;
          m_we = 0; m_done = 1; m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("instr_ready", {15'd0, instr_ready}, {15'd0, m_phase == 0});
    chk("write_enable", {15'd0, write_enable}, {15'd0, m_we});
    chk("done", {15'd0, done}, {15'd0, m_done});
    chk("carry", {15'd0, carry}, {15'd0, m_c});
    chk("zero", {15'd0, zero}, {15'd0, m_z});
    if (m_we) begin
      chk("write_address", {13'd0, write_address}, {13'd0, m_dest});
      chk("write_data", {12'd0, write_data}, {12'd0, m_wd});
    end
    if (m_phase == 1 || m_phase == 2) begin
      chk("read_address1", {13'd0, read_address1}, {13'd0, m_s1});
      chk("read_address2", {13'd0, read_address2}, {13'd0, m_s2});
    end
  end

  function automatic logic [15:0] enc(input int op, input int d, input int s1, input int s2,
                                      input int imm);
    return {3'(op), 3'(d), 3'(s1), 3'(s2), 4'(imm)};
  endfunction

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 16'd0, 16'd1);
    @(posedge clk); #1;
  endtask

  // Entered and left at negedge+1; the next call can be accepted in the done cycle.
  task automatic run(input logic [15:0] ins, input bit hold, input logic [15:0] next_ins,
                     input bit exp_we, input int exp_wd, input bit exp_c, input bit exp_z);
    logic [15:0] f;
    f = ins;
    instr = ins;
    instr_valid = 1'b1;
    wait_accept();
    if (hold) instr = next_ins;
    else instr_valid = 1'b0;
    chk("lit_ra1", {13'd0, read_address1}, {13'd0, f[9:7]});
    chk("lit_ra2", {13'd0, read_address2}, {13'd0, f[6:4]});
    repeat (2) @(posedge clk);
    #1;
    chk("lit_we", {15'd0, write_enable}, {15'd0, exp_we});
    if (exp_we) begin
      chk("lit_wa", {13'd0, write_address}, {13'd0, f[12:10]});
      chk("lit_wd", {12'd0, write_data}, 16'(exp_wd));
    end
    chk("lit_carry", {15'd0, carry}, {15'd0, exp_c});
    chk("lit_zero", {15'd0, zero}, {15'd0, exp_z});
    @(posedge clk); #1;
    chk("lit_done", {15'd0, done}, 16'd1);
    chk("lit_we_off", {15'd0, write_enable}, 16'd0);
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf[i]  = '0;
      mrf[i] = '0;
    end
    @(negedge clk); #1;
    chk("rst_ready", {15'd0, instr_ready}, 16'd1);
    chk("rst_we", {15'd0, write_enable}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_wd", {12'd0, write_data}, 16'd0);
    chk("rst_ra1", {13'd0, read_address1}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    run(enc(5, 1, 0, 0, 9), 0, '0, 1, 9, 0, 0);   // LOADI r1=9
    run(enc(5, 2, 0, 0, 7), 0, '0, 1, 7, 0, 0);   // LOADI r2=7
    run(enc(0, 3, 1, 2, 0), 0, '0, 1, 0, 1, 1);   // ADD r3=r1+r2 -> 16
    run(enc(1, 4, 2, 1, 0), 0, '0, 1, 14, 1, 0);  // SUB r4=r2-r1
    run(enc(1, 5, 1, 2, 0), 0, '0, 1, 2, 0, 0);   // SUB r5=r1-r2
    run(enc(7, 0, 0, 0, 0), 0, '0, 0, 0, 0, 0);   // NOP keeps flags
    run(enc(6, 6, 4, 0, 0), 1, enc(4, 7, 6, 6, 0), 1, 14, 0, 0);  // MOV r6=r4, XOR queued
    run(enc(4, 7, 6, 6, 0), 0, '0, 1, 0, 0, 1);   // XOR r7=r6^r6
    chk("lit_r6", {12'd0, rf[6]}, 16'd14);
    chk("lit_r3", {12'd0, rf[3]}, 16'd0);

    // Reset during EXEC of ADD r1=r1+r1.
    instr = enc(0, 1, 1, 1, 0);
    instr_valid = 1'b1;
    wait_accept();
    instr_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst_we", {15'd0, write_enable}, 16'd0);
    chk("arst_zero", {15'd0, zero}, 16'd0);
    chk("arst_carry", {15'd0, carry}, 16'd0);
    chk("arst_ready", {15'd0, instr_ready}, 16'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    instr = enc(5, 0, 0, 0, 5);                     // LOADI r0=5 on first edge
    instr_valid = 1'b1;
    @(posedge clk); #1;
    chk("first_accept", {15'd0, instr_ready}, 16'd0);
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_done", {15'd0, done}, 16'd1);
    chk("lit_r1_kept", {12'd0, rf[1]}, 16'd9);
    chk("lit_r0", {12'd0, rf[0]}, 16'd5);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) chk("regfile_vs_model", {12'd0, rf[i]}, {12'd0, mrf[i]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
